// File: rtl/and_unit_arbiter_if.sv
// Requester-side bus of the shared AND-unit arbiter: request/operand inputs,
// grant/response strobes, and the operand/result path to the external gate.
interface and_unit_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
);
  logic                      en;
  logic [N_REQ-1:0]          req;
  logic [N_REQ*DATA_W-1:0]   a_in;
  logic [N_REQ*DATA_W-1:0]   b_in;
  logic [N_REQ-1:0]          gnt;
  logic [N_REQ-1:0]          rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [DATA_W-1:0]         unit_a;
  logic [DATA_W-1:0]         unit_b;
  logic [DATA_W-1:0]         unit_y;
  logic                      busy;
  logic [CNT_W-1:0]          done_cnt;

  modport master (
    output en, req, a_in, b_in, unit_y,
    input  gnt, rsp_valid, rsp_data, unit_a, unit_b, busy, done_cnt
  );

  modport slave (
    input  en, req, a_in, b_in, unit_y,
    output gnt, rsp_valid, rsp_data, unit_a, unit_b, busy, done_cnt
  );
endinterface

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one external bitwise AND unit among
// N_REQ requesters: IDLE -> ISSUE -> RESP, one op per three cycles at most.
module and_unit_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  and_unit_arbiter_if.slave  bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [DATA_W-1:0]   unit_a_q, unit_a_d;
  logic [DATA_W-1:0]   unit_b_q, unit_b_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    done_cnt_q, done_cnt_d;
  logic [IDX_W:0]      pick_s;

  // Returns {found, index}; scanning offsets high-to-low lets the lowest
  // offset from the pointer overwrite any later candidate.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] jj;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      jj  = IDX_W'((int'(p) + k) % N_REQ);
      res = r[jj] ? {1'b1, jj} : res;
    end
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] sel_op(input logic [N_REQ*DATA_W-1:0] v,
                                               input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      r = (IDX_W'(i) == idx) ? v[i*DATA_W +: DATA_W] : r;
    end
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  // Next-state and next-output computation for the three-phase sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    unit_a_d    = '0;
    unit_b_d    = '0;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    done_cnt_d  = done_cnt_q;
    pick_s      = rr_pick(bus.req, ptr_q);

    case (state_q)
      IDLE: begin
        if (bus.en && pick_s[IDX_W]) begin
          win_d    = pick_s[IDX_W-1:0];
          unit_a_d = sel_op(bus.a_in, pick_s[IDX_W-1:0]);
          unit_b_d = sel_op(bus.b_in, pick_s[IDX_W-1:0]);
          gnt_d    = one_hot(pick_s[IDX_W-1:0]);
          state_d  = ISSUE;
        end else begin
          state_d  = IDLE;
        end
      end
      ISSUE: begin
        // unit_a/unit_b hold the staged operands for this cycle only.
        rsp_data_d  = bus.unit_y;
        rsp_valid_d = one_hot(win_q);
        state_d     = RESP;
      end
      RESP: begin
        ptr_d      = (win_q == IDX_W'(N_REQ - 1)) ? IDX_W'(0) : win_q + IDX_W'(1);
        done_cnt_d = (done_cnt_q == {CNT_W{1'b1}}) ? done_cnt_q
                                                   : done_cnt_q + CNT_W'(1);
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      unit_a_q    <= '0;
      unit_b_q    <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      unit_a_q    <= unit_a_d;
      unit_b_q    <= unit_b_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.unit_a    = unit_a_q;
  assign bus.unit_b    = unit_b_q;
  assign bus.busy      = busy_q;
  assign bus.done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Bench for and_unit_arbiter (N_REQ=4, DATA_W=8, CNT_W=8): a transaction-level
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_and_unit_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   chk_on;

  and_unit_arbiter_if #(.N_REQ(4), .DATA_W(8), .CNT_W(8)) bus ();

  // The shared gate lives outside the arbiter.
  assign bus.unit_y = bus.unit_a & bus.unit_b;

  and_unit_arbiter #(.N_REQ(4), .DATA_W(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: an op started when free and (en && req!=0); grant shows the next
  // cycle, response the one after, then one cycle to return to free.
  int         m_stage;
  int         m_ptr;
  int         m_w;
  logic [7:0] m_opa, m_opb;
  logic [3:0] m_gnt, m_rv;
  logic [7:0] m_ua, m_ub, m_rd, m_cnt;
  bit         m_busy;

  always @(posedge clk) begin
    m_gnt = 4'h0;
    m_rv  = 4'h0;
    m_ua  = 8'h00;
    m_ub  = 8'h00;
    if (rst) begin
      m_stage = 0;
      m_ptr   = 0;
      m_w     = 0;
      m_rd    = 8'h00;
      m_cnt   = 8'h00;
    end else if (m_stage == 0) begin
      if (bus.en && bus.req != 4'h0) begin
        for (int k = 3; k >= 0; k--) begin
          if (bus.req[(m_ptr + k) % 4]) m_w = (m_ptr + k) % 4;
        end
        m_opa   = bus.a_in[8*m_w +: 8];
        m_opb   = bus.b_in[8*m_w +: 8];
        m_gnt   = 4'(1 << m_w);
        m_ua    = m_opa;
        m_ub    = m_opb;
        m_stage = 1;
      end
    end else if (m_stage == 1) begin
      m_rv    = 4'(1 << m_w);
      m_rd    = m_opa & m_opb;
      m_stage = 2;
    end else begin
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      m_ptr   = (m_w + 1) % 4;
      m_stage = 0;
    end
    m_busy = (m_stage != 0);
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("gnt",       32'(bus.gnt),       32'(m_gnt));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
      chk("rsp_data",  32'(bus.rsp_data),  32'(m_rd));
      chk("unit_a",    32'(bus.unit_a),    32'(m_ua));
      chk("unit_b",    32'(bus.unit_b),    32'(m_ub));
      chk("busy",      32'(bus.busy),      32'(m_busy));
      chk("done_cnt",  32'(bus.done_cnt),  32'(m_cnt));
    end
  end

  logic [3:0] seen[$];
  logic [3:0] exp_seq [5];
  bit         got;

  task automatic wait_gnt(input logic [3:0] want, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      step(1);
      if (bus.gnt == want) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_gnt: got timeout want gnt=%0h", want);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    chk_on = 1'b0;
    rst    = 1'b1;
    bus.en   = 1'b0;
    bus.req  = 4'h0;
    bus.a_in = 32'h0;
    bus.b_in = 32'h0;
    step(2);
    chk_on = 1'b1;
    chk("rst_done_cnt", 32'(bus.done_cnt), 32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_gnt",      32'(bus.gnt),      32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);

    // Single request from requester 2, held one cycle.
    rst = 1'b0; bus.en = 1'b1; bus.req = 4'b0100;
    bus.a_in = 32'h0001_0000; bus.b_in = 32'h0001_0000;
    step(1);
    bus.req = 4'b0000;
    chk("t1_gnt",  32'(bus.gnt),  32'h4);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    step(1);
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h4);
    chk("t1_rsp_data",  32'(bus.rsp_data),  32'h1);
    chk("t1_busy2",     32'(bus.busy),      32'd1);
    step(1);
    chk("t1_done_cnt", 32'(bus.done_cnt), 32'd1);
    chk("t1_idle",     32'(bus.busy),     32'd0);

    // All four requesting: rotation 0,1,2,3,0 from a fresh pointer.
    rst = 1'b1; step(1); rst = 1'b0;
    bus.req = 4'b1111; bus.a_in = 32'h0101_0101; bus.b_in = 32'h0101_0101;
    for (int c = 0; c < 13; c++) begin
      step(1);
      if (bus.gnt != 4'h0) seen.push_back(bus.gnt);
    end
    bus.req = 4'b0000;
    step(3);
    exp_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    chk("t2_ngrants", 32'(seen.size()), 32'd5);
    for (int i = 0; i < seen.size() && i < 5; i++) chk("t2_seq", 32'(seen[i]), 32'(exp_seq[i]));

    // Byte-wide AND for requester 1.
    bus.req = 4'b0010; bus.a_in = 32'h0000_F000; bus.b_in = 32'h0000_3C00;
    step(1);
    bus.req = 4'b0000;
    chk("t3_gnt",    32'(bus.gnt),    32'h2);
    chk("t3_unit_a", 32'(bus.unit_a), 32'hF0);
    chk("t3_unit_b", 32'(bus.unit_b), 32'h3C);
    step(1);
    chk("t3_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("t3_rsp_data",  32'(bus.rsp_data),  32'h30);
    step(1);

    // Winner changes its operand during ISSUE; captured value is used.
    bus.req = 4'b1000; bus.a_in = 32'hFF00_0000; bus.b_in = 32'h0F00_0000;
    step(1);
    bus.a_in = 32'h0000_0000; bus.req = 4'b0000;
    chk("t4_gnt", 32'(bus.gnt), 32'h8);
    step(1);
    chk("t4_rsp_data", 32'(bus.rsp_data), 32'h0F);
    step(1);

    // Reset during ISSUE of requester 2 aborts the op.
    rst = 1'b1; step(1); rst = 1'b0;
    bus.req = 4'b1111; bus.a_in = 32'h1234_5678; bus.b_in = 32'hFFFF_FFFF;
    wait_gnt(4'b0100, 20, got);
    rst = 1'b1;
    step(1);
    chk("t5_no_rsp",   32'(bus.rsp_valid), 32'd0);
    chk("t5_cnt_clr",  32'(bus.done_cnt),  32'd0);
    rst = 1'b0;
    step(1);
    chk("t5_first_gnt", 32'(bus.gnt), 32'h1);
    step(2);

    // en=0 blocks grants; en dropped in ISSUE still lets the op finish.
    rst = 1'b1; bus.en = 1'b0; bus.req = 4'b0011;
    bus.a_in = 32'h0000_00AA; bus.b_in = 32'h0000_000F;
    step(1); rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      chk("t6_blk_gnt",  32'(bus.gnt),  32'd0);
      chk("t6_blk_busy", 32'(bus.busy), 32'd0);
    end
    bus.en = 1'b1;
    step(1);
    bus.en = 1'b0;
    chk("t6_gnt", 32'(bus.gnt), 32'h1);
    step(1);
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t6_rsp_data",  32'(bus.rsp_data),  32'h0A);
    step(1);
    for (int c = 0; c < 6; c++) begin
      step(1);
      chk("t6_no_gnt", 32'(bus.gnt), 32'd0);
    end

    // Counter saturation across 300+ ops.
    bus.en = 1'b1; bus.req = 4'b1111;
    step(905);
    bus.req = 4'b0000;
    step(4);
    chk("t7_sat", 32'(bus.done_cnt), 32'd255);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/and_unit_arbiter.md
Name: and_unit_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one bitwise AND unit among N_REQ requesters.
- The AND unit is a combinational gate array instantiated outside this block.
- Sits between the tile's input decode (requesters) and the shared gate; it owns operand staging, result capture, per-requester response strobes and a completed-operation counter.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 1, operand/result width in bits; the AND is applied bitwise.
- CNT_W, 8, width of the saturating completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  grant enable; sampled only in IDLE.
- req  input  N_REQ  per-requester request level.
- a_in  input  N_REQ*DATA_W  operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- b_in  input  N_REQ*DATA_W  operand B, same packing as a_in.
- gnt  output  N_REQ  one-hot grant, one-cycle pulse.
- rsp_valid  output  N_REQ  one-hot response strobe, one-cycle pulse.
- rsp_data  output  DATA_W  registered result; holds until the next response.
- unit_a  output  DATA_W  operand A to the shared AND unit.
- unit_b  output  DATA_W  operand B to the shared AND unit.
- unit_y  input  DATA_W  result from the shared AND unit (combinational a&b).
- busy  output  1  high whenever state != IDLE.
- done_cnt  output  CNT_W  count of completed operations, saturating at all-ones.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; gnt=0, rsp_valid=0, rsp_data=0, unit_a=0, unit_b=0, busy=0, done_cnt=0; round-robin pointer=0, so requester 0 has highest priority.
- FSM has 3 states: IDLE -> ISSUE -> RESP -> IDLE. There is no other path except reset.
- IDLE: if en=1 and req!=0, pick the winner w as the first set req bit searching upward from pointer with wrap-around. Latch a_in[w] and b_in[w] into staging registers and go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - gnt[w]=1.
  - unit_a and unit_b are driven from the staging registers.
  - At the closing edge: rsp_data <= unit_y; go to RESP.
- RESP (1 cycle):
  - rsp_valid[w]=1 and rsp_data is valid.
  - pointer <= (w+1) mod N_REQ.
  - done_cnt increments unless it is already all-ones.
  - Go to IDLE.
- Latency: req sampled in IDLE cycle T -> gnt in T+1 -> rsp_valid in T+2. Back in IDLE at T+3, so peak throughput is 1 operation per 3 cycles.
- Outside ISSUE, unit_a and unit_b are 0. gnt and rsp_valid are 0 outside their own states.
- Operands are captured only at the IDLE->ISSUE edge. Later changes to a_in, b_in or req of the winner do not affect the in-flight result.
- req is level-sensitive and not sticky:
  - A req dropped before it is sampled in IDLE is never granted.
  - A req still high when the FSM returns to IDLE counts as a new request. It competes at the rotated priority.
- en=0 in IDLE blocks new grants. en is ignored in ISSUE and RESP, so an in-flight op always completes.
- Reset mid-operation (ISSUE or RESP): the op is aborted. No rsp_valid is emitted on the following cycle, done_cnt is cleared and the pointer returns to 0.
- Fairness: with all requesters continuously active, grants cycle 0,1,...,N_REQ-1,0. No requester waits more than N_REQ ops.
- Unsupported requester indices (none when N_REQ is a power of 2) never win.

Test Plan:
- Reset, then req=4'b0100 with a=1, b=1 held for one cycle (DATA_W=1) -> gnt=0100 at T+1; rsp_valid=0100 and rsp_data=1 at T+2; busy high T+1..T+2; done_cnt=1.
- req=4'b1111 held, a[i]=b[i]=1 -> gnt sequence 0001,0010,0100,1000,0001 at 3-cycle spacing; exactly one rsp_valid per grant, matching the granted index.
- DATA_W=8, req[1] with a=0xF0, b=0x3C -> unit_a=0xF0, unit_b=0x3C during ISSUE; rsp_data=0x30 with rsp_valid=0010.
- Winner changes a_in to 0x00 in the ISSUE cycle (DATA_W=8, a=0xFF, b=0x0F) -> rsp_data=0x0F; the change is ignored.
- rst=1 during ISSUE of an op for requester 2 with req=1111 held -> no rsp_valid next cycle, done_cnt=0; after release the first gnt=0001.
- en=0 with req=0011 -> no gnt and busy=0 for 10 cycles. Set en=1, then en=0 in the ISSUE cycle -> that op completes (rsp_valid=0001) and no further grant follows. Run 300 ops with CNT_W=8 -> done_cnt stays at 255.
